fifo_flow_ctrl: RTL and testbench
=================================

Name: fifo_flow_ctrl

Overview:
Parametrised synchronous FIFO, successor to the single-size d1 FIFO. Adds generic width and depth, a registered read port with a valid strobe, and hysteretic pause generation from programmable almost-full/almost-empty thresholds. Errors are sticky and split by cause, and the occupancy count is exported. Sits between a producer and the downstream arbiter; fifo_pause is the back-pressure signal to the producer.

Parameters:
DATA_SIZE, 8, data word width in bits
ADDR_SIZE, 3, pointer width; DEPTH = 2**ADDR_SIZE entries (default 8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
push  input  1  write request
data_in  input  DATA_SIZE  write data
pop  input  1  read request
af_thr  input  ADDR_SIZE+1  almost-full threshold (count units)
ae_thr  input  ADDR_SIZE+1  almost-empty threshold (count units)
err_clr  input  1  clears sticky error bits
data_out  output  DATA_SIZE  registered read data
data_valid  output  1  one-cycle strobe, data_out updated
data_count  output  ADDR_SIZE+1  occupancy, 0..DEPTH
fifo_empty  output  1  count==0
fifo_full  output  1  count==DEPTH
almost_full  output  1  count>=af_thr
almost_empty  output  1  count<=ae_thr and count!=0
fifo_pause  output  1  registered hysteretic back-pressure
fifo_error  output  2  sticky; bit0 overflow, bit1 underflow

Behaviour:
- Reset (async, while high): wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, fifo_pause=0, fifo_error=2'b00. As a result fifo_empty=1 and all other flags are 0. Memory contents are not reset.
- Storage: DEPTH x DATA_SIZE internal array. Pointers are ADDR_SIZE bits and wrap naturally from DEPTH-1 to 0.
- Accept rules (evaluated on the current count):
  - pop_ok = pop & ~fifo_empty.
  - push_ok = push & (~fifo_full | pop_ok).
  - When full and both push and pop are asserted, both are accepted and the count is unchanged.
  - When empty and both are asserted, only the push is accepted; there is no bypass and data_valid stays 0.
- Count update: count_next = count + push_ok - pop_ok; the result never leaves 0..DEPTH.
- Write: on push_ok, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read:
  - On pop_ok, data_out <= mem[rd_ptr], rd_ptr increments, and data_valid is 1 in the next cycle (latency 1).
  - Otherwise data_valid=0 and data_out holds its last value.
- Status flags fifo_empty, fifo_full, almost_full and almost_empty are combinational from the registered count.
- fifo_pause, registered and updated every edge from count_next:
  - if count_next >= af_thr, set to 1;
  - else if count_next <= ae_thr, clear to 0;
  - else hold.
  - Set has priority when af_thr <= ae_thr (misconfiguration).
- Errors:
  - Bit0 (overflow) sets when push & ~push_ok.
  - Bit1 (underflow) sets when pop & ~pop_ok.
  - Bits remain set until err_clr; a set event in the same cycle as err_clr wins.
  - A rejected request has no effect on pointers or count.
- Thresholds are sampled every cycle, so changing them mid-operation takes effect on the next edge.
- Reset asserted mid-operation discards all queued data immediately. The first push after reset release writes entry 0.

Test Plan:
- Reset, then push 8 words 0x10..0x17 with af_thr=6, ae_thr=2 -> data_count=8, fifo_full=1, almost_full=1 from count 6, fifo_pause=1 in the same cycle count becomes 6.
- On full, push 0xAA without pop -> fifo_error=2'b01, count stays 8, 0xAA is never read out. Then err_clr -> fifo_error=2'b00.
- Drain with continuous pop -> data_out=0x10..0x17 in order, each with data_valid=1 one cycle after its pop. fifo_pause drops only when count reaches 2, not at 5. fifo_empty=1 after the eighth pop.
- Pop on empty -> fifo_error=2'b10, data_valid=0, data_out holds 0x17.
- Full plus simultaneous push 0x55 and pop -> 0x10 is read out, count stays 8, no error. 0x55 comes out last after wrap-around.
- Empty plus simultaneous push 0x33 and pop -> count=1, fifo_error=2'b10. The next pop returns 0x33. Asserting reset mid-burst clears count, outputs and errors asynchronously.

Source files
------------

// File: rtl/fifo_flow_ctrl.sv
// Parametrised synchronous FIFO with a registered read port, occupancy export,
// hysteretic producer back-pressure and sticky, cause-split error bits.
module fifo_flow_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   af_thr,
  input  logic [ADDR_SIZE:0]   ae_thr,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [ADDR_SIZE:0]   data_count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_pause,
  output logic [1:0]           fifo_error
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]   CNT_FULL = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0]   CNT_ONE  = (ADDR_SIZE + 1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 pause_q, pause_d;
  logic [1:0]           error_q, error_d;
  logic                 push_ok, pop_ok;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= af_thr);
  assign almost_empty = (count_q <= ae_thr) && !fifo_empty;

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_count = count_q;
  assign fifo_pause = pause_q;
  assign fifo_error = error_q;

  always_comb begin
    pop_ok  = pop & ~fifo_empty;
    // a pop frees a slot in the same cycle, so a full FIFO still takes a push
    push_ok = push & (~fifo_full | pop_ok);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pause_d      = pause_q;
    error_d      = err_clr ? 2'b00 : error_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      data_out_d   = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end

    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;

    // set is tested first so it wins on misconfigured thresholds
    if (count_d >= af_thr)      pause_d = 1'b1;
    else if (count_d <= ae_thr) pause_d = 1'b0;

    if (push && !push_ok) error_d[0] = 1'b1;
    if (pop && !pop_ok)   error_d[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pause_q      <= 1'b0;
      error_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pause_q      <= pause_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Bench for fifo_flow_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_fifo_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, err_clr;
  logic [7:0] data_in;
  logic [3:0] af_thr, ae_thr;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] data_count;
  logic       fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause;
  logic [1:0] fifo_error;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_pause;
  logic [1:0] m_err;

  fifo_flow_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(3)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .data_count(data_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_pause(fifo_pause), .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0; m_valid = 1'b0; m_pause = 1'b0; m_err = 2'b00;
  endtask

  task automatic model_step(input logic p, input logic [7:0] d, input logic o, input logic c);
    int  cnt;
    bit  pop_ok, push_ok;
    cnt     = q.size();
    pop_ok  = o && (cnt > 0);
    push_ok = p && ((cnt < 8) || pop_ok);
    m_valid = pop_ok;
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    if (q.size() >= int'(af_thr))      m_pause = 1'b1;
    else if (q.size() <= int'(ae_thr)) m_pause = 1'b0;
    if (c) m_err = 2'b00;
    if (p && !push_ok) m_err[0] = 1'b1;
    if (o && !pop_ok)  m_err[1] = 1'b1;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",        32'(data_count),   n);
    chk("empty",        32'(fifo_empty),   32'(n == 0));
    chk("full",         32'(fifo_full),    32'(n == 8));
    chk("almost_full",  32'(almost_full),  32'(n >= int'(af_thr)));
    chk("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_thr) && n != 0));
    chk("pause",        32'(fifo_pause),   32'(m_pause));
    chk("error",        32'(fifo_error),   32'(m_err));
    chk("valid",        32'(data_valid),   32'(m_valid));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  task automatic step(input logic p, input logic [7:0] d, input logic o, input logic c);
    push = p; data_in = d; pop = o; err_clr = c;
    @(posedge clk);
    model_step(p, d, o, c);
    #1;
    check_all();
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    af_thr = 4'd6; ae_thr = 4'd2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // fill; pause must rise on the edge where count becomes 6
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == 5) chk("pause_at_6", 32'(fifo_pause), 1);
    end
    chk("fill_count", 32'(data_count), 8);
    chk("fill_full",  32'(fifo_full),  1);

    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("overflow_err", 32'(fifo_error), 32'(2'b01));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("err_cleared", 32'(fifo_error), 0);

    // drain; pause holds through count 5..3, drops at 2
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(data_out), 32'(8'h10 + 8'(i)));
      if (i == 2) chk("pause_hold_5", 32'(fifo_pause), 1);
      if (i == 5) chk("pause_drop_2", 32'(fifo_pause), 0);
    end
    chk("drained_empty", 32'(fifo_empty), 1);

    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_err",  32'(fifo_error), 32'(2'b10));
    chk("underflow_hold", 32'(data_out),   32'h17);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_pushpop_data",  32'(data_out),   32'h10);
    chk("full_pushpop_count", 32'(data_count), 8);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last", 32'(data_out), 32'h55);

    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("empty_pushpop_count", 32'(data_count), 1);
    chk("empty_pushpop_valid", 32'(data_valid), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_pushpop_data", 32'(data_out), 32'h33);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // random traffic with shifting thresholds, including af_thr <= ae_thr
    for (int i = 0; i < 400; i++) begin
      logic p, o, c;
      if (i % 50 == 0) begin
        af_thr = 4'($urandom_range(0, 8));
        ae_thr = 4'($urandom_range(0, 8));
      end
      if ((i / 25) % 2 == 0) begin
        p = ($urandom_range(0, 3) != 0); o = ($urandom_range(0, 3) == 0);
      end else begin
        p = ($urandom_range(0, 3) == 0); o = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 15) == 0);
      step(p, 8'($urandom), o, c);
    end

    // mid-burst asynchronous reset
    af_thr = 4'd6; ae_thr = 4'd2;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), (i > 2), 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_reset_count", 32'(data_count), 0);
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_first", 32'(data_out), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
